// File: rtl/column_approx_div_pkg.sv
// Shared types and sizing helpers for the column-truncated approximate divider.
package column_approx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of restoring iterations once THETA quotient columns are dropped.
    function automatic int iter_count(input int length, input int theta);
        return length - theta;
    endfunction

    function automatic int cnt_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/column_approx_div_if.sv
// Operand/result valid-ready bundle for column_approx_div.
interface column_approx_div_if #(
    parameter int LENGTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*LENGTH-1:0]   z;
    logic [LENGTH-1:0]     y;
    logic                  out_valid;
    logic                  out_ready;
    logic [LENGTH-1:0]     q;
    logic [LENGTH-1:0]     r;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, q, r, ovf, dbz
    );

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, q, r, ovf, dbz
    );
endinterface

// File: rtl/column_approx_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module column_approx_div_step #(
    parameter int LENGTH = 8
) (
    input  logic [LENGTH-1:0] rem_i,
    input  logic [LENGTH-1:0] div_i,
    input  logic              bit_i,
    output logic [LENGTH-1:0] rem_o,
    output logic              q_bit_o
);

    logic [LENGTH:0] shifted;
    logic [LENGTH:0] diff;

    // The widened shift keeps the carry-out so the compare is exact.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, div_i};
    assign q_bit_o = (shifted >= {1'b0, div_i});
    assign rem_o   = LENGTH'(q_bit_o ? diff : shifted);

endmodule

// File: rtl/column_approx_div.sv
// Sequential shift-subtract divider that drops THETA low quotient columns.
// Define COLUMN_APPROX_DIV_RND_EN to set the top truncated bit when the remainder is non-zero.
module column_approx_div
    import column_approx_pkg::*;
#(
    parameter int LENGTH = 8,
    parameter int THETA  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    column_approx_div_if.slave io
);

    localparam int ITERS = iter_count(LENGTH, THETA);
    localparam int CNT_W = cnt_width(LENGTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LENGTH-1:0]   rem_q, rem_d;
    logic [LENGTH-1:0]   dvd_q, dvd_d;
    logic [LENGTH-1:0]   div_q, div_d;
    logic [LENGTH-1:0]   quo_q, quo_d;
    logic [LENGTH-1:0]   q_q, q_d;
    logic [LENGTH-1:0]   r_q, r_d;
    logic                ovf_q, ovf_d;
    logic                dbz_q, dbz_d;

    logic [LENGTH-1:0]   step_rem;
    logic                step_qbit;
    logic [LENGTH-1:0]   quo_next;
    logic [LENGTH-1:0]   q_trunc;
    logic [LENGTH-1:0]   q_final;

    column_approx_div_step #(
        .LENGTH (LENGTH)
    ) u_step (
        .rem_i   (rem_q),
        .div_i   (div_q),
        .bit_i   (dvd_q[LENGTH-1]),
        .rem_o   (step_rem),
        .q_bit_o (step_qbit)
    );

    assign quo_next = LENGTH'({quo_q, step_qbit});
    assign q_trunc  = quo_next << THETA;

`ifdef COLUMN_APPROX_DIV_RND_EN
    localparam logic [LENGTH-1:0] RND_MASK =
        (THETA > 0) ? (LENGTH'(1) << ((THETA > 0) ? THETA - 1 : 0)) : '0;
    assign q_final = q_trunc | ((step_rem != '0) ? RND_MASK : '0);
`else
    assign q_final = q_trunc;
`endif

    // NOTE: every target gets its hold value first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    state_d = BUSY;
                    rem_d   = io.z[2*LENGTH-1:LENGTH];
                    dvd_d   = io.z[LENGTH-1:0];
                    div_d   = io.y;
                    quo_d   = '0;
                    cnt_d   = '0;
                end
            end

            BUSY: begin
                // The loaded remainder is the dividend's upper half, so the first
                // cycle doubles as the overflow check; later remainders are always < y.
                if ((cnt_q == '0) && (rem_q >= div_q)) begin
                    state_d = DONE;
                    q_d     = '1;
                    r_d     = '0;
                    ovf_d   = 1'b1;
                    dbz_d   = (div_q == '0);
                end else begin
                    rem_d = step_rem;
                    dvd_d = dvd_q << 1;
                    quo_d = quo_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_d = DONE;
                        q_d     = q_final;
                        r_d     = step_rem;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b0;
                    end
                end
            end

            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.q         = q_q;
    assign io.r         = r_q;
    assign io.ovf       = ovf_q;
    assign io.dbz       = dbz_q;

endmodule

// File: tb/tb_column_approx_div.sv
// Directed self-checking bench for column_approx_div with LENGTH=8, THETA=1.
module tb_column_approx_div;

    localparam int L  = 8;
    localparam int TH = 1;

`ifdef COLUMN_APPROX_DIV_RND_EN
    localparam logic [7:0] Q_100_7  = 8'd15;
    localparam logic [7:0] Q_1000_9 = 8'd111;
`else
    localparam logic [7:0] Q_100_7  = 8'd14;
    localparam logic [7:0] Q_1000_9 = 8'd110;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    column_approx_div_if #(.LENGTH(L)) bus ();

    column_approx_div #(
        .LENGTH (L),
        .THETA  (TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] z, input logic [7:0] y);
        bus.in_valid = 1'b1;
        bus.z        = z;
        bus.y        = y;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [15:0] z, input logic [7:0] y,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic eovf, input logic edbz, input int elat);
        int lat;
        check({tag, "_rdy_before"}, 32'(bus.in_ready), 32'd1);
        start(z, y);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_q"},   32'(bus.q), 32'(eq));
        check({tag, "_r"},   32'(bus.r), 32'(er));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
        check({tag, "_dbz"}, 32'(bus.dbz), 32'(edbz));
        check({tag, "_rdy_done"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_vld_after"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.z         = '0;
        bus.y         = '0;

        #12;
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_q",   32'(bus.q), 32'd0);
        check("rst_r",   32'(bus.r), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_dbz", 32'(bus.dbz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run("d100_7",   16'd100,    8'd7,    Q_100_7,  8'd1, 1'b0, 1'b0, 7);
        run("d101_7",   16'd101,    8'd7,    Q_100_7,  8'd1, 1'b0, 1'b0, 7);
        run("d2048_16", 16'd2048,   8'd16,   8'd128,   8'd0, 1'b0, 1'b0, 7);
        run("d1000_9",  16'd1000,   8'd9,    Q_1000_9, 8'd5, 1'b0, 1'b0, 7);
        run("ovf",      16'h1000,   8'h10,   8'hFF,    8'd0, 1'b1, 1'b0, 1);
        run("dbz",      16'h0123,   8'h00,   8'hFF,    8'd0, 1'b1, 1'b1, 1);

        // Consumer already ready: one-cycle result, in_ready back right after.
        bus.out_ready = 1'b1;
        start(16'd2048, 8'd16);
        wait_valid(lat);
        check("stream_lat", 32'(lat), 32'd7);
        check("stream_q", 32'(bus.q), 32'd128);
        tick();
        check("stream_vld_after", 32'(bus.out_valid), 32'd0);
        check("stream_rdy_after", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;

        // Stall in DONE while a new request is offered.
        start(16'd100, 8'd7);
        wait_valid(lat);
        check("hold_lat", 32'(lat), 32'd7);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.z        = 16'd2048;
            bus.y        = 8'd16;
            tick();
            check("hold_vld", 32'(bus.out_valid), 32'd1);
            check("hold_rdy", 32'(bus.in_ready), 32'd0);
            check("hold_q",   32'(bus.q), 32'(Q_100_7));
            check("hold_r",   32'(bus.r), 32'd1);
            check("hold_ovf", 32'(bus.ovf), 32'd0);
            check("hold_dbz", 32'(bus.dbz), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hold_release_vld", 32'(bus.out_valid), 32'd0);
        check("hold_release_rdy", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset in the middle of iteration 3.
        start(16'd100, 8'd7);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 32'(bus.in_ready), 32'd1);
        check("arst_vld", 32'(bus.out_valid), 32'd0);
        check("arst_q",   32'(bus.q), 32'd0);
        check("arst_r",   32'(bus.r), 32'd0);
        check("arst_ovf", 32'(bus.ovf), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("arst_no_stale_vld", 32'(bus.out_valid), 32'd0);
        end
        run("post_rst", 16'd100, 8'd7, Q_100_7, 8'd1, 1'b0, 1'b0, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
